// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle between cache_fill_ctrl, the I/D caches and main memory.
// master: the fill controller; slave: the caches and memory side.
interface cache_fill_ctrl_if #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    localparam int WL = $clog2(WORDS);

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              i_busy;
    logic              d_busy;
    logic              i_data_we;
    logic              d_data_we;
    logic              i_tag_we;
    logic              d_tag_we;
    logic [WL-1:0]     fill_word;
    logic [DATA_W-1:0] fill_data;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  mem_data_valid, mem_data_in,
        output mem_en, mem_addr, i_busy, d_busy,
        output i_data_we, d_data_we, i_tag_we, d_tag_we,
        output fill_word, fill_data
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output mem_data_valid, mem_data_in,
        input  mem_en, mem_addr, i_busy, d_busy,
        input  i_data_we, d_data_we, i_tag_we, d_tag_we,
        input  fill_word, fill_data
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Block-fill controller for I/D cache misses, D-side first.
// Issues one read per cycle, streams returned words, writes tag on last.
module cache_fill_ctrl #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    cache_fill_ctrl_if.master bus
);
    localparam int WL = $clog2(WORDS);
    localparam int CW = WL + 1;
    localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(2 * WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_nx;
    logic              owner, owner_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              en_q, en_nx;
    logic [CW-1:0]     issue_cnt, issue_nx;
    logic [WL-1:0]     rcv_cnt, rcv_nx;
    logic              fill_we;
    logic              last;

    // issue_cnt counts requests already placed on the bus (incl. the current one)
    assign fill_we = (state == FILL) && bus.mem_data_valid;
    assign last    = (rcv_cnt == WL'(WORDS - 1));

    assign bus.mem_en    = en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.i_busy    = (state == FILL) && !owner;
    assign bus.d_busy    = (state == FILL) && owner;
    assign bus.i_data_we = fill_we && !owner;
    assign bus.d_data_we = fill_we && owner;
    assign bus.i_tag_we  = fill_we && !owner && last;
    assign bus.d_tag_we  = fill_we && owner && last;
    assign bus.fill_word = rcv_cnt;
    assign bus.fill_data = bus.mem_data_in;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            base      <= '0;
            addr_q    <= '0;
            en_q      <= 1'b0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            base      <= base_nx;
            addr_q    <= addr_nx;
            en_q      <= en_nx;
            issue_cnt <= issue_nx;
            rcv_cnt   <= rcv_nx;
        end
    end

    // Next-state: grant in IDLE, issue and receive independently in FILL
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        base_nx  = base;
        addr_nx  = addr_q;
        en_nx    = en_q;
        issue_nx = issue_cnt;
        rcv_nx   = rcv_cnt;
        unique case (state)
            IDLE: begin
                if (bus.d_miss || bus.i_miss) begin
                    owner_nx = bus.d_miss;
                    base_nx  = (bus.d_miss ? bus.d_miss_addr
                                           : bus.i_miss_addr) & MASK;
                    addr_nx  = base_nx;
                    en_nx    = 1'b1;
                    issue_nx = CW'(1);
                    rcv_nx   = '0;
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (issue_cnt < CW'(WORDS)) begin
                    en_nx    = 1'b1;
                    addr_nx  = base + (ADDR_W'(issue_cnt) << 1);
                    issue_nx = issue_cnt + CW'(1);
                end else begin
                    en_nx = 1'b0;
                end
                if (bus.mem_data_valid) begin
                    rcv_nx = rcv_cnt + WL'(1);
                    if (last) begin
                        state_nx = IDLE;
                        en_nx    = 1'b0;
                        issue_nx = '0;
                        rcv_nx   = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl with a small in-order memory model.
// Cycle 0 of each scenario is the first cycle a miss is presented.
module tb_cache_fill_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_fill_ctrl_if #(.WORDS(8), .ADDR_W(16)) bus ();

    cache_fill_ctrl #(.WORDS(8), .ADDR_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        en;
        logic [15:0] addr;
        logic        ib, db, iwe, dwe, itag, dtag;
        logic [2:0]  word;
        logic [15:0] data;
    } samp_t;

    typedef struct {
        logic        dm;
        logic        en;
        logic [15:0] addr;
        logic        db;
        logic        dwe;
        logic        dtag;
        logic [2:0]  word;
    } vec_t;

    samp_t       s;
    vec_t        tbl [14];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          mode = 0;
    bit          sched [64];
    logic [15:0] q_addr [$];
    int          q_cyc [$];
    logic [15:0] exp_data;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    task automatic begin_scn(input int m);
        q_addr.delete();
        q_cyc.delete();
        foreach (sched[k]) sched[k] = 1'b0;
        mode = m;
        cyc = 0;
    endtask

    // mode 0: latency 4; mode 1: scheduled in-order returns; mode 2: stray strobes
    task automatic eval();
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in = 16'h0000;
        if (q_addr.size() > 0 &&
            ((mode == 0 && q_cyc[0] + 4 == cyc) ||
             (mode == 1 && cyc < 64 && sched[cyc]))) begin
            bus.mem_data_valid = 1'b1;
            exp_data = q_addr[0] ^ 16'hA5A5;
            bus.mem_data_in = exp_data;
            void'(q_addr.pop_front());
            void'(q_cyc.pop_front());
        end else if (mode == 2 && cyc < 64 && sched[cyc]) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_in = 16'hDEAD;
        end
        #1;
        s.en   = bus.mem_en;
        s.addr = bus.mem_addr;
        s.ib   = bus.i_busy;
        s.db   = bus.d_busy;
        s.iwe  = bus.i_data_we;
        s.dwe  = bus.d_data_we;
        s.itag = bus.i_tag_we;
        s.dtag = bus.d_tag_we;
        s.word = bus.fill_word;
        s.data = bus.fill_data;
        if (s.en === 1'b1) begin
            q_addr.push_back(s.addr);
            q_cyc.push_back(cyc);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int dtag_c, itag_c, ireq_c, dfirst, overlap, grant_ok;
        int en_cnt, nrecv, dwe_cnt, en_first, en_last, bad, stray;
        logic [15:0] ireq_a, dreq_a, first_a, last_a;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 1'b1, 16'h1230, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 1'b1, 16'h1232, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{1'b1, 1'b1, 16'h1236, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[5]  = '{1'b1, 1'b1, 16'h1238, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[6]  = '{1'b1, 1'b1, 16'h123A, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[7]  = '{1'b1, 1'b1, 16'h123C, 1'b1, 1'b1, 1'b0, 3'd2};
        tbl[8]  = '{1'b1, 1'b1, 16'h123E, 1'b1, 1'b1, 1'b0, 3'd3};
        tbl[9]  = '{1'b1, 1'b0, 16'h123E, 1'b1, 1'b1, 1'b0, 3'd4};
        tbl[10] = '{1'b1, 1'b0, 16'h123E, 1'b1, 1'b1, 1'b0, 3'd5};
        tbl[11] = '{1'b1, 1'b0, 16'h123E, 1'b1, 1'b1, 1'b0, 3'd6};
        tbl[12] = '{1'b1, 1'b0, 16'h123E, 1'b1, 1'b1, 1'b1, 3'd7};
        tbl[13] = '{1'b0, 1'b0, 16'h123E, 1'b0, 1'b0, 1'b0, 3'd0};

        bus.i_miss = 1'b0;
        bus.i_miss_addr = 16'h0000;
        bus.d_miss = 1'b0;
        bus.d_miss_addr = 16'h0000;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in = 16'h0000;
        exp_data = 16'h0000;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", bus.mem_en, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_busy", {bus.i_busy, bus.d_busy}, 0);
        chk("rst_word", bus.fill_word, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single D-miss, table-driven per-cycle expectations
        begin_scn(0);
        bus.d_miss_addr = 16'h1236;
        for (int k = 0; k < 14; k++) begin
            bus.d_miss = tbl[k].dm;
            eval();
            chk("s1_en", s.en, tbl[k].en);
            chk("s1_addr", s.addr, tbl[k].addr);
            chk("s1_dbusy", s.db, tbl[k].db);
            chk("s1_dwe", s.dwe, tbl[k].dwe);
            chk("s1_dtag", s.dtag, tbl[k].dtag);
            chk("s1_iside", {s.ib, s.iwe, s.itag}, 0);
            if (tbl[k].dwe) begin
                chk("s1_word", s.word, tbl[k].word);
                chk("s1_data", s.data, exp_data);
            end
            adv();
        end

        // simultaneous I and D misses: D first, I right after
        begin_scn(0);
        bus.d_miss = 1'b1;
        bus.d_miss_addr = 16'h8000;
        bus.i_miss = 1'b1;
        bus.i_miss_addr = 16'h0040;
        dtag_c = -1; itag_c = -1; ireq_c = -1; dfirst = -1;
        overlap = 0; grant_ok = 0;
        ireq_a = 16'h0; dreq_a = 16'h0;
        for (int k = 0; k < 40; k++) begin
            eval();
            if (s.db && s.ib) overlap++;
            if (s.dtag && dtag_c < 0) dtag_c = cyc;
            if (s.itag && itag_c < 0) itag_c = cyc;
            if (s.en && s.db && dfirst < 0) begin
                dfirst = cyc;
                dreq_a = s.addr;
            end
            if (s.en && s.ib && ireq_c < 0) begin
                ireq_c = cyc;
                ireq_a = s.addr;
            end
            if (cyc == 13) grant_ok = (!s.ib && !s.db) ? 1 : 0;
            adv();
            if (s.dtag) bus.d_miss = 1'b0;
            if (s.itag) bus.i_miss = 1'b0;
        end
        chk("s2_dfirst_cyc", dfirst, 1);
        chk("s2_dfirst_addr", dreq_a, 16'h8000);
        chk("s2_dtag_cyc", dtag_c, 12);
        chk("s2_idle_c13", grant_ok, 1);
        chk("s2_ireq_cyc", ireq_c, 14);
        chk("s2_ireq_addr", ireq_a, 16'h0040);
        chk("s2_itag_cyc", itag_c, 25);
        chk("s2_overlap", overlap, 0);

        // I-miss with irregular memory return gaps
        begin_scn(1);
        sched[5] = 1; sched[7] = 1; sched[8] = 1; sched[12] = 1;
        sched[13] = 1; sched[20] = 1; sched[21] = 1; sched[30] = 1;
        bus.i_miss = 1'b1;
        bus.i_miss_addr = 16'h2000;
        en_cnt = 0; nrecv = 0; dwe_cnt = 0; itag_c = -1;
        en_first = -1; en_last = -1;
        for (int k = 0; k < 36; k++) begin
            eval();
            if (s.en) begin
                en_cnt++;
                if (en_first < 0) en_first = cyc;
                en_last = cyc;
            end
            if (s.dwe) dwe_cnt++;
            if (s.iwe) begin
                chk("s3_word", s.word, nrecv);
                nrecv++;
            end
            if (s.itag && itag_c < 0) itag_c = cyc;
            adv();
            if (s.itag) bus.i_miss = 1'b0;
        end
        chk("s3_en_cnt", en_cnt, 8);
        chk("s3_en_span", {en_first[7:0], en_last[7:0]}, {8'd1, 8'd8});
        chk("s3_recv", nrecv, 8);
        chk("s3_dwe", dwe_cnt, 0);
        chk("s3_itag_cyc", itag_c, 30);

        // top-of-memory block: no wrap
        begin_scn(0);
        bus.d_miss = 1'b1;
        bus.d_miss_addr = 16'hFFFE;
        en_cnt = 0; bad = 0; dtag_c = -1;
        first_a = 16'h0; last_a = 16'h0;
        for (int k = 0; k < 16; k++) begin
            eval();
            if (s.en) begin
                if (en_cnt == 0) first_a = s.addr;
                last_a = s.addr;
                if (s.addr < 16'hFFF0) bad++;
                en_cnt++;
            end
            if (s.dtag && dtag_c < 0) dtag_c = cyc;
            adv();
            if (s.dtag) bus.d_miss = 1'b0;
        end
        chk("s4_first", first_a, 16'hFFF0);
        chk("s4_last", last_a, 16'hFFFE);
        chk("s4_en_cnt", en_cnt, 8);
        chk("s4_wrap", bad, 0);
        chk("s4_dtag_cyc", dtag_c, 12);

        // asynchronous reset in the middle of a fill
        begin_scn(0);
        bus.d_miss = 1'b1;
        bus.d_miss_addr = 16'h1236;
        stray = 0;
        for (int k = 0; k < 7; k++) begin
            eval();
            if (s.dtag || s.itag) stray++;
            adv();
        end
        eval();
        chk("s5_pre_dwe", s.dwe, 1);
        rst_n = 1'b0;
        bus.d_miss = 1'b0;
        #1;
        chk("s5_rst_en", bus.mem_en, 0);
        chk("s5_rst_addr", bus.mem_addr, 0);
        chk("s5_rst_busy", {bus.i_busy, bus.d_busy}, 0);
        chk("s5_rst_we", {bus.d_data_we, bus.d_tag_we}, 0);
        adv();
        rst_n = 1'b1;
        begin_scn(2);
        cyc = 8;
        for (int k = 8; k <= 12; k++) sched[k] = 1'b1;
        for (int k = 8; k <= 12; k++) begin
            eval();
            if (s.dwe || s.iwe || s.dtag || s.itag || s.en) stray++;
            adv();
        end
        chk("s5_stray", stray, 0);
        mode = 0;
        bus.d_miss = 1'b1;
        bus.d_miss_addr = 16'h4444;
        dfirst = -1; dreq_a = 16'h0; dtag_c = -1; nrecv = 0;
        for (int k = 0; k < 16; k++) begin
            eval();
            if (s.en && dfirst < 0) begin
                dfirst = cyc;
                dreq_a = s.addr;
            end
            if (s.dwe) begin
                chk("s5_word", s.word, nrecv);
                nrecv++;
            end
            if (s.dtag && dtag_c < 0) dtag_c = cyc;
            adv();
            if (s.dtag) bus.d_miss = 1'b0;
        end
        chk("s5_req_cyc", dfirst, 14);
        chk("s5_req_addr", dreq_a, 16'h4440);
        chk("s5_recv", nrecv, 8);
        chk("s5_dtag_cyc", dtag_c, 25);

        // memory strobes while idle are ignored
        begin_scn(2);
        sched[0] = 1; sched[1] = 1; sched[2] = 1;
        for (int k = 0; k < 3; k++) begin
            eval();
            chk("s6_we", {s.iwe, s.dwe, s.itag, s.dtag}, 0);
            chk("s6_en", s.en, 0);
            adv();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller between the pipelined CPU's instruction/data caches and the multi-cycle main memory. On an I-cache or D-cache miss it fetches the whole 8-word (16-byte) block containing the miss address. It streams each returned word into the owning cache's data array and writes the tag once the last word lands. The D-cache has priority, and only one fill is outstanding at a time.

## Interface
Parameters:
- WORDS, 8, words per block (power of 2; block = 2*WORDS bytes)
- ADDR_W, 16, address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_miss  in  1  I-cache miss; held high by the cache until it sees i_tag_we
- i_miss_addr  in  16  byte address of the I-miss
- d_miss  in  1  D-cache miss; same hold rule
- d_miss_addr  in  16  byte address of the D-miss
- mem_data_valid  in  1  main memory return strobe, one word per pulse, in issue order
- mem_data_in  in  16  returned word
- mem_en  out  1  memory read request this cycle
- mem_addr  out  16  request address
- i_busy  out  1  a fill for the I-cache is in progress
- d_busy  out  1  a fill for the D-cache is in progress
- i_data_we / d_data_we  out  1  write fill_data into the selected cache at fill_word
- i_tag_we / d_tag_we  out  1  write the tag and valid bit for the block being filled
- fill_word  out  3  word index within block (log2 WORDS bits)
- fill_data  out  16  data to write; combinational pass-through of mem_data_in

## Operation
- States: IDLE, FILL.
- Registers:
  - owner (0=I, 1=D)
  - base[15:0], block-aligned: miss_addr with the low log2(2*WORDS) bits cleared
  - issue_cnt (0..WORDS, saturating)
  - rcv_cnt (0..WORDS-1)
- IDLE:
  - If d_miss, latch d_miss_addr and set owner=D. Else if i_miss, latch i_miss_addr and set owner=I. Go to FILL, with issue_cnt=0 and rcv_cnt=0.
  - No miss: stay in IDLE.
  - mem_data_valid is ignored in IDLE.
- FILL, issue side:
  - While issue_cnt<WORDS: mem_en=1, mem_addr=base+2*issue_cnt, and issue_cnt increments each cycle.
  - Requests go out on consecutive cycles; memory is pipelined and accepts one per cycle.
  - At issue_cnt==WORDS: mem_en=0 and mem_addr holds its last value.
- FILL, receive side:
  - Each mem_data_valid pulses the owner's data_we for one cycle, with fill_word=rcv_cnt; then rcv_cnt increments.
  - A valid arriving in the same cycle as an issue is handled independently.
- Completion:
  - On the valid with rcv_cnt==WORDS-1, the owner's tag_we pulses in the same cycle as the last data_we.
  - The next state is IDLE.
- Busy outputs:
  - i_busy = FILL & owner==I; d_busy = FILL & owner==D.
  - The non-owner's busy stays 0 while the other side is filled; the CPU stalls that side on its own miss signal.
- Simultaneous misses: D is served first. I is granted in the IDLE cycle that follows D completion.
- A miss already held high is not re-latched while in FILL. It is sampled only in IDLE.
- Reset at any time:
  - state=IDLE, all counters 0, base=0, mem_addr=0.
  - All enables, busy and write-enable outputs drop to 0 immediately. An aborted fill never writes a tag.
  - Memory returns still in flight after reset release arrive in IDLE and are ignored.

## Timing
- mem_en, mem_addr, i_busy, d_busy and fill_word are registered (Moore).
- data_we and tag_we are Mealy: owner & FILL & mem_data_valid. fill_data is combinational.
- Default memory latency is 4 cycles (request in cycle t, data valid in t+4). The controller counts strobes and has no latency dependency.
- Cycle map for a single miss seen in cycle 0:
  - busy and the first request in cycle 1; requests in cycles 1-8.
  - data_we in cycles 5-12; tag_we in cycle 12.
  - IDLE and busy=0 in cycle 13.
- Miss-to-tag latency is 12 cycles. A back-to-back second miss is granted in cycle 13, and its first request goes out in cycle 14.

## Test plan
- Single D-miss at addr 0x1236 with a latency-4 memory model returning addr^0xA5A5 -> mem_addr sequence 0x1230,0x1232,...,0x123E in cycles 1-8. d_data_we in cycles 5-12 with fill_word 0..7 and correct data; d_tag_we only in cycle 12; d_busy high cycles 1-12; i_* outputs 0.
- i_miss and d_miss raised together (I 0x0040, D 0x8000) -> D filled first (base 0x8000, tag at cycle 12). I granted at cycle 13, first I request 0x0040 at cycle 14, i_tag_we at cycle 25.
- Memory with irregular gaps between valids (valids at cycles 5,7,8,12,13,20,21,30) -> fill_word increments only on valids; tag_we at cycle 30; mem_en still exactly 8 cycles.
- Address 0xFFFE miss -> base 0xFFF0, last request 0xFFFE, no wrap past 0xFFFE.
- rst_n pulsed low at cycle 7 of a fill -> all outputs 0 asynchronously. Stray valids at cycles 8-12 produce no data_we or tag_we; a new miss after release restarts from word 0.
- mem_data_valid pulsed in IDLE with no miss pending -> no write enables, mem_en stays 0.
